// File: rtl/multicycle_control.sv
// Moore FSM sequencing a multicycle MIPS datapath (fetch/decode/execute/memory/writeback).
// Define MULTICYCLE_JAL_JR_EN to add the JAL and JR states (codes 13 and 14).
module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] OP,
   input  logic [5:0] Funct,
   input  logic       MemReady,
   output logic       IorD,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       Branch,
   output logic       ULASrcA,
   output logic [1:0] ULASrcB,
   output logic [2:0] ULAControl,
   output logic [1:0] PCSrc,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic       Illegal,
   output logic [3:0] State
);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MULTICYCLE_JAL_JR_EN
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] FN_JR   = 6'b001000;
`endif

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11,
`ifdef MULTICYCLE_JAL_JR_EN
      S_JAL     = 4'd13,
      S_JR      = 4'd14,
`endif
      S_ILLEGAL = 4'd12
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic       w_funct_ok;
   logic [2:0] w_funct_alu;

   always_comb begin
      w_funct_ok  = 1'b1;
      w_funct_alu = 3'b010;
      case (Funct)
         6'b100000: w_funct_alu = 3'b010;
         6'b100010: w_funct_alu = 3'b110;
         6'b100100: w_funct_alu = 3'b000;
         6'b100101: w_funct_alu = 3'b001;
         6'b100111: w_funct_alu = 3'b011;
         6'b101010: w_funct_alu = 3'b111;
         default:   w_funct_ok  = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:  w_next = MemReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (OP)
               OP_LW, OP_SW: w_next = S_MEMADR;
`ifdef MULTICYCLE_JAL_JR_EN
               OP_R:         w_next = (Funct == FN_JR) ? S_JR : S_EXEC;
               OP_JAL:       w_next = S_JAL;
`else
               OP_R:         w_next = S_EXEC;
`endif
               OP_BEQ:       w_next = S_BRANCH;
               OP_ADDI:      w_next = S_ADDIEX;
               OP_J:         w_next = S_JUMP;
               default:      w_next = S_ILLEGAL;
            endcase
         end
         S_MEMADR: w_next = (OP == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  w_next = MemReady ? S_MEMWB : S_MEMRD;
         S_MEMWR:  w_next = MemReady ? S_FETCH : S_MEMWR;
         S_EXEC:   w_next = w_funct_ok ? S_ALUWB : S_ILLEGAL;
         S_ADDIEX: w_next = S_ADDIWB;
         default:  w_next = S_FETCH;
      endcase
   end

   always_comb begin
      IorD       = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      Branch     = 1'b0;
      ULASrcA    = 1'b0;
      ULASrcB    = 2'b00;
      ULAControl = 3'b000;
      PCSrc      = 2'b00;
      RegDst     = 2'b00;
      MemtoReg   = 2'b00;
      Illegal    = 1'b0;
      State      = r_state;
      case (r_state)
         S_FETCH: begin
            ULASrcB    = 2'b01;
            ULAControl = 3'b010;
            IRWrite    = MemReady;
            PCWrite    = MemReady;
         end
         S_DECODE: begin
            ULASrcB    = 2'b11;
            ULAControl = 3'b010;
         end
         S_MEMADR, S_ADDIEX: begin
            ULASrcA    = 1'b1;
            ULASrcB    = 2'b10;
            ULAControl = 3'b010;
         end
         S_MEMRD: IorD = 1'b1;
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 2'b01;
         end
         S_MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXEC: begin
            ULASrcA    = 1'b1;
            ULAControl = w_funct_alu;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            RegDst   = 2'b01;
         end
         S_BRANCH: begin
            ULASrcA    = 1'b1;
            ULAControl = 3'b110;
            Branch     = 1'b1;
            PCSrc      = 2'b01;
         end
         S_ADDIWB: RegWrite = 1'b1;
         S_JUMP: begin
            PCSrc   = 2'b10;
            PCWrite = 1'b1;
         end
         S_ILLEGAL: Illegal = 1'b1;
`ifdef MULTICYCLE_JAL_JR_EN
         S_JAL: begin
            RegWrite = 1'b1;
            RegDst   = 2'b10;
            MemtoReg = 2'b10;
            PCSrc    = 2'b10;
            PCWrite  = 1'b1;
         end
         S_JR: begin
            PCSrc   = 2'b11;
            PCWrite = 1'b1;
         end
`endif
         default: ;
      endcase
      // Reset masks the registered state so enables drop in the same cycle it is raised.
      if (reset) begin
         IorD       = 1'b0;
         IRWrite    = 1'b0;
         PCWrite    = 1'b0;
         MemWrite   = 1'b0;
         RegWrite   = 1'b0;
         Branch     = 1'b0;
         ULASrcA    = 1'b0;
         ULASrcB    = 2'b01;
         ULAControl = 3'b010;
         PCSrc      = 2'b00;
         RegDst     = 2'b00;
         MemtoReg   = 2'b00;
         Illegal    = 1'b0;
         State      = 4'd0;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised self-checking bench for multicycle_control against a per-instruction path model.
module tb_multicycle_control;

`ifdef MULTICYCLE_JAL_JR_EN
   localparam bit JALJR = 1'b1;
`else
   localparam bit JALJR = 1'b0;
`endif

   // {State, IorD, IRWrite, PCWrite, MemWrite, RegWrite, Branch, ULASrcA,
   //  ULASrcB, ULAControl, PCSrc, RegDst, MemtoReg, Illegal}
   localparam logic [22:0] RESET_WORD = {4'd0, 7'b0, 2'b01, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0};

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] OP, Funct;
   logic       MemReady;
   logic       IorD, IRWrite, PCWrite, MemWrite, RegWrite, Branch, ULASrcA, Illegal;
   logic [1:0] ULASrcB, PCSrc, RegDst, MemtoReg;
   logic [2:0] ULAControl;
   logic [3:0] State;
   logic [22:0] w_obs;

   int n_checks = 0;
   int n_errors = 0;

   logic [4:0]  path[$];   // {MemReady driven, expected state code} per cycle
   logic [22:0] obs[$];

   multicycle_control dut (
      .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .MemReady(MemReady),
      .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .Branch(Branch), .ULASrcA(ULASrcA), .ULASrcB(ULASrcB),
      .ULAControl(ULAControl), .PCSrc(PCSrc), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .Illegal(Illegal), .State(State)
   );

   assign w_obs = {State, IorD, IRWrite, PCWrite, MemWrite, RegWrite, Branch, ULASrcA,
                   ULASrcB, ULAControl, PCSrc, RegDst, MemtoReg, Illegal};

   always #5 clk = ~clk;

   function automatic logic [3:0] funct_info(input logic [5:0] fn);
      case (fn)
         6'h20:   return {1'b1, 3'b010};
         6'h22:   return {1'b1, 3'b110};
         6'h24:   return {1'b1, 3'b000};
         6'h25:   return {1'b1, 3'b001};
         6'h27:   return {1'b1, 3'b011};
         6'h2a:   return {1'b1, 3'b111};
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // Sequence of states an instruction walks through, given FETCH and memory wait counts.
   function automatic void build_path(input logic [5:0] op, input logic [5:0] fn,
                                      input int unsigned fw, input int unsigned mw);
      logic [3:0] fi;
      fi = funct_info(fn);
      path.delete();
      for (int unsigned i = 0; i < fw; i++) path.push_back({1'b0, 4'd0});
      path.push_back({1'b1, 4'd0});
      path.push_back({rb(), 4'd1});
      case (op)
         6'h23: begin
            path.push_back({rb(), 4'd2});
            for (int unsigned i = 0; i < mw; i++) path.push_back({1'b0, 4'd3});
            path.push_back({1'b1, 4'd3});
            path.push_back({rb(), 4'd4});
         end
         6'h2b: begin
            path.push_back({rb(), 4'd2});
            for (int unsigned i = 0; i < mw; i++) path.push_back({1'b0, 4'd5});
            path.push_back({1'b1, 4'd5});
         end
         6'h00: begin
            if (JALJR && fn == 6'h08) path.push_back({rb(), 4'd14});
            else begin
               path.push_back({rb(), 4'd6});
               path.push_back({rb(), fi[3] ? 4'd7 : 4'd12});
            end
         end
         6'h04: path.push_back({rb(), 4'd8});
         6'h08: begin
            path.push_back({rb(), 4'd9});
            path.push_back({rb(), 4'd10});
         end
         6'h02: path.push_back({rb(), 4'd11});
         6'h03: path.push_back({rb(), JALJR ? 4'd13 : 4'd12});
         default: path.push_back({rb(), 4'd12});
      endcase
   endfunction

   function automatic logic [22:0] model_out(input logic [3:0] st, input logic [5:0] fn, input logic mr);
      logic iord, irw, pcw, memw, regw, br, srca, ill;
      logic [1:0] srcb, pcsrc, regdst, m2r;
      logic [2:0] alu;
      logic [3:0] fi;
      {iord, irw, pcw, memw, regw, br, srca, ill} = '0;
      {srcb, pcsrc, regdst, m2r} = '0;
      alu = '0;
      fi = funct_info(fn);
      case (st)
         4'd0:  begin srcb = 2'b01; alu = 3'b010; irw = mr; pcw = mr; end
         4'd1:  begin srcb = 2'b11; alu = 3'b010; end
         4'd2, 4'd9: begin srca = 1'b1; srcb = 2'b10; alu = 3'b010; end
         4'd3:  iord = 1'b1;
         4'd4:  begin regw = 1'b1; m2r = 2'b01; end
         4'd5:  begin iord = 1'b1; memw = 1'b1; end
         4'd6:  begin srca = 1'b1; alu = fi[2:0]; end
         4'd7:  begin regw = 1'b1; regdst = 2'b01; end
         4'd8:  begin srca = 1'b1; alu = 3'b110; br = 1'b1; pcsrc = 2'b01; end
         4'd10: regw = 1'b1;
         4'd11: begin pcsrc = 2'b10; pcw = 1'b1; end
         4'd12: ill = 1'b1;
         4'd13: begin regw = 1'b1; regdst = 2'b10; m2r = 2'b10; pcsrc = 2'b10; pcw = 1'b1; end
         4'd14: begin pcsrc = 2'b11; pcw = 1'b1; end
         default: ;
      endcase
      return {st, iord, irw, pcw, memw, regw, br, srca, srcb, alu, pcsrc, regdst, m2r, ill};
   endfunction

   // ULAControl is left unconstrained in EXEC when the funct is not a supported one.
   function automatic logic [22:0] cmp_mask(input logic [3:0] st, input logic [5:0] fn);
      logic [3:0] fi;
      fi = funct_info(fn);
      if (st == 4'd6 && !fi[3]) return ~(23'h7 << 7);
      return '1;
   endfunction

   task automatic run_path(input logic [5:0] op, input logic [5:0] fn);
      obs.delete();
      foreach (path[k]) begin
         @(negedge clk);
         OP = op; Funct = fn; MemReady = path[k][4];
         #1;
         obs.push_back(w_obs);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; MemReady = 1'b1; OP = 6'h23; Funct = 6'h20;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         n_checks++;
         if (w_obs !== RESET_WORD) begin
            n_errors++;
            $display("FAIL reset_outputs cycle %0d: observed %h, expected %h", i, w_obs, RESET_WORD);
         end
      end
      MemReady = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_rtype();
      build_path(6'h00, 6'h20, 0, 0);
      run_path(6'h00, 6'h20);
      foreach (path[k]) begin
         n_checks++;
         if ((obs[k] & cmp_mask(path[k][3:0], 6'h20)) !== (model_out(path[k][3:0], 6'h20, path[k][4]) & cmp_mask(path[k][3:0], 6'h20))) begin
            n_errors++;
            $display("FAIL rtype_add cycle %0d: observed %h, expected %h", k, obs[k], model_out(path[k][3:0], 6'h20, path[k][4]));
         end
      end
   endtask

   task automatic test_lw_wait();
      int iord_cycles = 0;
      build_path(6'h23, 6'h11, 0, 2);
      run_path(6'h23, 6'h11);
      foreach (path[k]) begin
         if (obs[k][18]) iord_cycles++;
         n_checks++;
         if (obs[k] !== model_out(path[k][3:0], 6'h11, path[k][4])) begin
            n_errors++;
            $display("FAIL lw_wait cycle %0d: observed %h, expected %h", k, obs[k], model_out(path[k][3:0], 6'h11, path[k][4]));
         end
      end
      n_checks++;
      if (iord_cycles !== 3) begin
         n_errors++;
         $display("FAIL lw_iord_cycles: observed %0d, expected 3", iord_cycles);
      end
   endtask

   task automatic test_sw_wait();
      int memw_cycles = 0;
      int regw_cycles = 0;
      build_path(6'h2b, 6'h05, 0, 1);
      run_path(6'h2b, 6'h05);
      foreach (path[k]) begin
         if (obs[k][15]) memw_cycles++;
         if (obs[k][14]) regw_cycles++;
         n_checks++;
         if (obs[k] !== model_out(path[k][3:0], 6'h05, path[k][4])) begin
            n_errors++;
            $display("FAIL sw_wait cycle %0d: observed %h, expected %h", k, obs[k], model_out(path[k][3:0], 6'h05, path[k][4]));
         end
      end
      n_checks++;
      if (memw_cycles !== 2 || regw_cycles !== 0) begin
         n_errors++;
         $display("FAIL sw_enable_counts: observed memwrite=%0d regwrite=%0d, expected memwrite=2 regwrite=0", memw_cycles, regw_cycles);
      end
   endtask

   task automatic test_branch_jump();
      logic [5:0] ops[2] = '{6'h04, 6'h02};
      foreach (ops[j]) begin
         build_path(ops[j], 6'h3f, 0, 0);
         run_path(ops[j], 6'h3f);
         foreach (path[k]) begin
            n_checks++;
            if (obs[k] !== model_out(path[k][3:0], 6'h3f, path[k][4])) begin
               n_errors++;
               $display("FAIL branch_jump op %h cycle %0d: observed %h, expected %h", ops[j], k, obs[k], model_out(path[k][3:0], 6'h3f, path[k][4]));
            end
         end
      end
   endtask

   task automatic test_illegal();
      logic [5:0] ops[2] = '{6'h3f, 6'h00};
      logic [5:0] fns[2] = '{6'h20, 6'h00};
      foreach (ops[j]) begin
         int pulses = 0;
         build_path(ops[j], fns[j], 1, 0);
         run_path(ops[j], fns[j]);
         foreach (path[k]) begin
            if (obs[k][0]) pulses++;
            n_checks++;
            if ((obs[k] & cmp_mask(path[k][3:0], fns[j])) !== (model_out(path[k][3:0], fns[j], path[k][4]) & cmp_mask(path[k][3:0], fns[j]))) begin
               n_errors++;
               $display("FAIL illegal op %h cycle %0d: observed %h, expected %h", ops[j], k, obs[k], model_out(path[k][3:0], fns[j], path[k][4]));
            end
         end
         n_checks++;
         if (pulses !== 1) begin
            n_errors++;
            $display("FAIL illegal_pulse op %h: observed %0d pulses, expected 1", ops[j], pulses);
         end
      end
   endtask

   task automatic test_reset_mid_memwr();
      build_path(6'h2b, 6'h00, 0, 3);
      while (path.size() > 4) void'(path.pop_back());
      run_path(6'h2b, 6'h00);
      foreach (path[k]) begin
         n_checks++;
         if (obs[k] !== model_out(path[k][3:0], 6'h00, path[k][4])) begin
            n_errors++;
            $display("FAIL reset_mid_memwr lead-in cycle %0d: observed %h, expected %h", k, obs[k], model_out(path[k][3:0], 6'h00, path[k][4]));
         end
      end
      @(negedge clk);
      MemReady = 1'b0; reset = 1'b1;
      #1;
      n_checks++;
      if (w_obs !== RESET_WORD) begin
         n_errors++;
         $display("FAIL reset_mid_memwr same cycle: observed %h, expected %h", w_obs, RESET_WORD);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++;
      if (w_obs !== model_out(4'd0, 6'h00, 1'b0)) begin
         n_errors++;
         $display("FAIL reset_mid_memwr next cycle: observed %h, expected %h", w_obs, model_out(4'd0, 6'h00, 1'b0));
      end
   endtask

   task automatic test_jal_jr();
      logic [5:0] ops[2] = '{6'h03, 6'h00};
      logic [5:0] fns[2] = '{6'h2a, 6'h08};
      foreach (ops[j]) begin
         build_path(ops[j], fns[j], 0, 0);
         run_path(ops[j], fns[j]);
         foreach (path[k]) begin
            n_checks++;
            if ((obs[k] & cmp_mask(path[k][3:0], fns[j])) !== (model_out(path[k][3:0], fns[j], path[k][4]) & cmp_mask(path[k][3:0], fns[j]))) begin
               n_errors++;
               $display("FAIL jal_jr op %h cycle %0d: observed %h, expected %h", ops[j], k, obs[k], model_out(path[k][3:0], fns[j], path[k][4]));
            end
         end
      end
   endtask

   task automatic test_random();
      logic [5:0] op_pool[8] = '{6'h00, 6'h08, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03, 6'h00};
      logic [5:0] fn_pool[8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h08, 6'h00};
      for (int n = 0; n < 80; n++) begin
         logic [5:0] op, fn;
         op = ($urandom_range(0, 9) < 8) ? op_pool[$urandom_range(0, 7)] : 6'($urandom);
         fn = ($urandom_range(0, 9) < 8) ? fn_pool[$urandom_range(0, 7)] : 6'($urandom);
         build_path(op, fn, $urandom_range(0, 2), $urandom_range(0, 3));
         run_path(op, fn);
         foreach (path[k]) begin
            n_checks++;
            if ((obs[k] & cmp_mask(path[k][3:0], fn)) !== (model_out(path[k][3:0], fn, path[k][4]) & cmp_mask(path[k][3:0], fn))) begin
               n_errors++;
               $display("FAIL random instr %0d op %h funct %h cycle %0d: observed %h, expected %h", n, op, fn, k, obs[k], model_out(path[k][3:0], fn, path[k][4]));
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1; OP = '0; Funct = '0; MemReady = 1'b0;
      test_reset();
      test_rtype();
      test_lw_wait();
      test_sw_wait();
      test_branch_jump();
      test_illegal();
      test_reset_mid_memwr();
      test_jal_jr();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
